// File: rtl/ddc_pkg.sv
// Shared widths, result type and the round/saturate helper for the DDC
// mixer/decimator datapath.
package ddc_pkg;

    // Default datapath widths; the top-level parameters default to these
    // and must keep them, because the derived widths below follow them.
    localparam int DEF_ADC_W     = 12;
    localparam int DEF_NCO_W     = 12;
    localparam int DEF_OUT_W     = 16;
    localparam int DEF_LOG2R_MAX = 4;

    localparam int PROD_W     = DEF_ADC_W + DEF_NCO_W;
    localparam int ACC_W      = PROD_W + DEF_LOG2R_MAX;
    localparam int SHIFT_BASE = PROD_W - DEF_OUT_W;

    // Rounded/saturated output word plus a flag telling whether it clipped.
    typedef struct packed {
        logic [DEF_OUT_W-1:0] y;
        logic                 clip;
    } sat_t;

    // Round half up by adding 2^(s-1) before the arithmetic shift, then
    // clip to the signed output range. The sum is formed one bit wider than
    // the accumulator so the rounding constant can never wrap it.
    function automatic sat_t sat_round(input logic signed [ACC_W-1:0] acc,
                                       input logic [3:0]              s);
        logic signed [ACC_W:0] biased;
        logic signed [ACC_W:0] y;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        sat_t                  r;
        hi     = (ACC_W+1)'(2**(DEF_OUT_W-1) - 1);
        lo     = (ACC_W+1)'(-(2**(DEF_OUT_W-1)));
        biased = (ACC_W+1)'(acc) + ((ACC_W+1)'(1) <<< (s - 4'd1));
        y      = biased >>> s;
        r.y    = y[DEF_OUT_W-1:0];
        r.clip = 1'b0;
        if (y > hi) begin
            r.y    = {1'b0, {(DEF_OUT_W-1){1'b1}}};
            r.clip = 1'b1;
        end else if (y < lo) begin
            r.y    = {1'b1, {(DEF_OUT_W-1){1'b0}}};
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddc_mixer_decim_intdump.sv
// One channel of the integrate-and-dump: block accumulator followed by the
// rounding/saturating output register. Block control is shared by the top.
module ddc_intdump
    import ddc_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clken,
    input  logic                        vld,
    input  logic                        load,
    input  logic                        dump,
    input  logic signed [PROD_W-1:0]    prod,
    input  logic [3:0]                  shift,
    output logic signed [DEF_OUT_W-1:0] y,
    output logic                        clip
);

    logic signed [ACC_W-1:0] acc;
    sat_t                    sat;

    // Round and saturate the finished block sum that sits in the accumulator.
    always_comb begin
        sat = sat_round(acc, shift);
    end

    assign clip = sat.clip;

    // S3: first product of a block loads the sum, later ones add to it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clken && vld) begin
            acc <= load ? ACC_W'(prod) : acc + ACC_W'(prod);
        end
    end

    // S4: capture the scaled word when the block has just been dumped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y <= '0;
        end else if (clken && dump) begin
            y <= $signed(sat.y);
        end
    end

endmodule

// File: rtl/ddc_mixer_decim.sv
// Quadrature mixer plus integrate-and-dump decimator running in lock-step
// with the NCO: register, multiply, accumulate, round/saturate.
module ddc_mixer_decim
    import ddc_pkg::*;
#(
    parameter int ADC_W     = DEF_ADC_W,
    parameter int NCO_W     = DEF_NCO_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int LOG2R_MAX = DEF_LOG2R_MAX
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    nco_valid,
    input  logic signed [ADC_W-1:0] adc_i,
    input  logic signed [NCO_W-1:0] fsin_i,
    input  logic signed [NCO_W-1:0] fcos_i,
    input  logic [2:0]              log2r,
    input  logic [1:0]              gain,
    input  logic                    ovf_clr,
    output logic signed [OUT_W-1:0] i_o,
    output logic signed [OUT_W-1:0] q_o,
    output logic                    out_valid,
    output logic                    ovf_o
);

    logic                     vld_p1;
    logic signed [ADC_W-1:0]  adc_p1;
    logic signed [NCO_W-1:0]  sin_p1;
    logic signed [NCO_W-1:0]  cos_p1;

    logic                     vld_p2;
    logic signed [PROD_W-1:0] pi_p2;
    logic signed [PROD_W-1:0] pq_p2;

    logic [LOG2R_MAX-1:0]     cnt;
    logic [2:0]               log2r_eff;
    logic [1:0]               gain_eff;
    logic                     dump_p3;

    logic [2:0]               log2r_clamp;
    logic [2:0]               cur_log2r;
    logic [LOG2R_MAX:0]       r_full;
    logic [LOG2R_MAX-1:0]     last_cnt;
    logic                     blk_start;
    logic                     last;
    logic [3:0]               shift;
    logic                     clip_i;
    logic                     clip_q;

    // S1: capture the sample and NCO pair; a missing nco_valid becomes a bubble.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (clken) begin
            vld_p1 <= nco_valid;
            adc_p1 <= adc_i;
            sin_p1 <= fsin_i;
            cos_p1 <= fcos_i;
        end
    end

    // S2: full-precision mixing products; Q takes the negated sine product.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
        end else if (clken) begin
            vld_p2 <= vld_p1;
            pi_p2  <= adc_p1 * cos_p1;
            pq_p2  <= -(adc_p1 * sin_p1);
        end
    end

    // Block bookkeeping: a block's length comes from the live log2r at its
    // first product and from the latched copy afterwards.
    always_comb begin
        log2r_clamp = (log2r > 3'(LOG2R_MAX)) ? 3'(LOG2R_MAX) : log2r;
        blk_start   = vld_p2 && (cnt == '0);
        cur_log2r   = blk_start ? log2r_clamp : log2r_eff;
        r_full      = (LOG2R_MAX+1)'(1) << cur_log2r;
        last_cnt    = LOG2R_MAX'(r_full - (LOG2R_MAX+1)'(1));
        last        = vld_p2 && (cnt == last_cnt);
        shift       = 4'(log2r_eff) + 4'(SHIFT_BASE) - 4'(gain_eff);
    end

    // S3 control: sample counter, per-block parameter latches, dump marker.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            log2r_eff <= '0;
            gain_eff  <= '0;
            dump_p3   <= 1'b0;
        end else if (clken) begin
            dump_p3 <= last;
            if (vld_p2) begin
                cnt <= last ? '0 : cnt + LOG2R_MAX'(1);
            end
            if (blk_start) begin
                log2r_eff <= log2r_clamp;
                gain_eff  <= gain;
            end
        end
    end

    ddc_intdump u_chan_i (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .vld     (vld_p2),
        .load    (blk_start),
        .dump    (dump_p3),
        .prod    (pi_p2),
        .shift   (shift),
        .y       (i_o),
        .clip    (clip_i)
    );

    ddc_intdump u_chan_q (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .vld     (vld_p2),
        .load    (blk_start),
        .dump    (dump_p3),
        .prod    (pq_p2),
        .shift   (shift),
        .y       (q_o),
        .clip    (clip_q)
    );

    // S4 status: one-cycle output strobe and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            out_valid <= clken && dump_p3;
            if (clken && dump_p3 && (clip_i || clip_q)) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ddc_mixer_decim.md
# ddc_mixer_decim

Quadrature mixer and integrate-and-dump decimator placed directly downstream of the NCO in the receive DDC path. Multiplies each signed ADC sample by the NCO cosine/sine pair, sums blocks of 2^log2r products per channel, and rounds, scales and saturates the sums into I/Q words. The NCO's `clken` and `out_valid` qualify the pipeline, so the block runs in lock-step with the NCO.

## Interface
- `ADC_W`, 12: signed ADC sample width.
- `NCO_W`, 12: signed NCO sine/cosine width (matches NCO `mpr`).
- `OUT_W`, 16: signed I/Q output width.
- `LOG2R_MAX`, 4: maximum decimation exponent; the accumulator is `ADC_W+NCO_W+LOG2R_MAX` bits wide.

- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `clken` in 1: pipeline advance enable, same signal as the NCO's.
- `nco_valid` in 1: NCO `out_valid`.
- `adc_i` in ADC_W: signed ADC sample.
- `fsin_i` in NCO_W: NCO sine.
- `fcos_i` in NCO_W: NCO cosine.
- `log2r` in 3: decimation exponent; values above LOG2R_MAX clamp to LOG2R_MAX.
- `gain` in 2: output left-shift, 0 to 3.
- `ovf_clr` in 1: clears `ovf_o`.
- `i_o` out OUT_W: in-phase output.
- `q_o` out OUT_W: quadrature output.
- `out_valid` out 1: one-cycle strobe marking new I/Q.
- `ovf_o` out 1: sticky saturation flag.

## Operation
- Accept condition: `clken=1` and `nco_valid=1` on the same edge. With `clken=0` every stage holds and `out_valid` is 0. With `nco_valid=0` and `clken=1`, no sample is accepted and a bubble propagates.
- S1 register stage: latch `adc_i`, `fsin_i`, `fcos_i` together with a valid bit.
- S2 multiply stage (full-precision signed products, PROD_W = ADC_W+NCO_W = 24):
  - pi = adc·cos
  - pq = −(adc·sin)
  - The extreme case (−2048)·(−2048) = +2^22 fits in 24 bits.
- S3 accumulate stage, per channel:
  - The first valid product of a block loads the accumulator; later valid products add to it.
  - Sample counter runs 0 to R−1, where R = 2^log2r_eff. On count R−1 a dump occurs.
- Parameter latching: `log2r_eff` and `gain_eff` are latched only at block start (counter = 0 and a valid product arrives) and stay constant for the whole block. Changes to `log2r`/`gain` mid-block take effect at the next block.
- S4 output stage:
  - Shift s = log2r_eff + (PROD_W − OUT_W) − gain_eff (= log2r_eff + 8 − gain_eff by default; always ≥ 5).
  - Rounded value y = (acc + 2^(s−1)) >>> s (arithmetic shift, round half up).
  - Saturate y to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. Any clipping on either channel sets `ovf_o`.
- `ovf_o` is sticky and is cleared by `ovf_clr`. If a set and a clear land on the same cycle, the set wins.
- Reset (`reset_n=0` at a clk edge) clears:
  - all pipeline valid bits, accumulators and the counter;
  - `log2r_eff` and `gain_eff` to 0;
  - `i_o`, `q_o`, `out_valid` and `ovf_o` to 0.
  
  A partial block is discarded. The first block after reset starts with the first accepted sample.

## Timing
- Latency: `out_valid` rises on the 3rd clken-qualified edge after the edge that accepted the block's last sample.
  - With `clken` held high, that is 3 clk cycles.
  - Edges with `clken=0` stretch the latency but lose no data.
- `out_valid` lasts one clk cycle.
- `i_o`/`q_o` hold their value until the next dump.
- Throughput: one sample per accepted edge. Output rate is accept rate / R. With log2r_eff = 0, every sample produces an output.
- The counter wraps R−1 → 0 on a dump. There is no idle cycle between blocks.
- A bubble (`nco_valid=0`) does not advance the counter or change the accumulator.

## Structure
- Package `ddc_pkg` holds:
  - constants PROD_W, ACC_W = PROD_W + LOG2R_MAX, SHIFT_BASE = PROD_W − OUT_W;
  - function `sat_round(acc, s)` that returns the rounded/saturated value and a clip flag.
- Sub-module `ddc_intdump` implements the per-channel accumulate, round and saturate stages (S3–S4).
  - It is instantiated twice (I and Q).
  - Counter, parameter latches and `ovf_o` are shared in the top level.

## Test plan
- **Reset:** assert `reset_n=0` mid-block with log2r=2 → all outputs 0; the first post-reset output comes after 4 fresh samples and excludes pre-reset data.
- **No decimation:** log2r=0, gain=0, adc=1000, cos=2047, sin=0, clken=1 → `out_valid` every cycle after 3-cycle latency, i_o=7996, q_o=0.
- **Decimate by 4:** log2r=2, gain=0, adc=−2048, cos=−2048, sin=2047 → `out_valid` once per 4 samples, i_o=16384, q_o=16376.
- **Gating:** random `clken`/`nco_valid` gaps with log2r=3 → outputs equal a reference model over accepted samples only; nothing changes while clken=0.
- **Parameter changes:** change log2r from 2 to 4 at counter=1 → the current block still sums 4 samples, the next sums 16. log2r=7 → behaves as 4.
- **Saturation:** gain=3, log2r=0, adc=−2048, cos=−2048 → i_o=32767 and ovf_o=1, held sticky; `ovf_clr` on the same cycle as a new clip leaves ovf_o=1; `ovf_clr` alone clears it.
